// File: rtl/psdsqrt_hs.sv
// Bit-serial square root with fractional bits, optional guard-bit rounding and
// ready/valid handshakes on both the operand and the result side.
module psdsqrt_hs #(
  parameter  int NBITSIN = 32,
  parameter  int NFRAC   = 4,
  parameter  int ROUND   = 1,
  localparam int NOUT    = NBITSIN / 2 + NFRAC
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [NBITSIN-1:0] xin,
  output logic               in_ready,
  input  logic               abort,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NOUT-1:0]    sqrt,
  output logic               exact,
  output logic               sat
);

  localparam int NITER = NOUT + ROUND;
  localparam int RW    = 2 * NITER;
  localparam int REMW  = NITER + 2;
  localparam int CW    = $clog2(NITER);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     r_q, r_d;
  logic [NITER-1:0]  q_q, q_d;
  logic [REMW-1:0]   rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NOUT-1:0]   sqrt_q, sqrt_d;
  logic              exact_q, exact_d;
  logic              sat_q, sat_d;

  logic [RW-1:0]     r_init;
  logic [REMW+1:0]   r2;
  logic [REMW+1:0]   trial;
  logic [REMW+1:0]   diff;
  logic              take_bit;
  logic [NOUT-1:0]   res_val;
  logic              res_sat;

  // Radicand is left-aligned so the low pad supplies the fractional and guard pairs.
  always_comb begin
    r_init = '0;
    r_init[RW-1 -: NBITSIN] = xin;
  end

  always_comb begin
    r2       = {rem_q, r_q[RW-1 -: 2]};
    trial    = {2'b00, q_q, 2'b01};
    diff     = r2 - trial;
    take_bit = (r2 >= trial);
  end

  generate
    if (ROUND != 0) begin : g_round
      logic [NOUT:0] sum;
      // The guard bit is added back in; a carry out means the result no longer fits.
      always_comb begin
        sum     = {1'b0, q_q[NITER-1:1]} + {{NOUT{1'b0}}, q_q[0]};
        res_sat = sum[NOUT];
        res_val = sum[NOUT] ? {NOUT{1'b1}} : sum[NOUT-1:0];
      end
    end else begin : g_trunc
      always_comb begin
        res_val = q_q;
        res_sat = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sqrt_d  = sqrt_q;
    exact_d = exact_q;
    sat_d   = sat_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          r_d     = r_init;
          q_d     = '0;
          rem_d   = '0;
          cnt_d   = CW'(NITER - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        r_d   = {r_q[RW-3:0], 2'b00};
        q_d   = {q_q[NITER-2:0], take_bit};
        rem_d = REMW'(take_bit ? diff : r2);
        if (cnt_q == '0) begin
          state_d = FINAL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FINAL: begin
        sqrt_d  = res_val;
        exact_d = (rem_q == '0);
        sat_d   = res_sat;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over whatever the computation would have done this edge.
    if (abort && (state_q == RUN || state_q == FINAL)) begin
      state_d = IDLE;
      sqrt_d  = sqrt_q;
      exact_d = exact_q;
      sat_d   = sat_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sqrt_q  <= '0;
      exact_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sqrt_q  <= sqrt_d;
      exact_q <= exact_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN) || (state_q == FINAL);
  assign out_valid = (state_q == DONE);
  assign sqrt      = sqrt_q;
  assign exact     = exact_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_psdsqrt_hs.sv
// Bench for psdsqrt_hs: a rounding instance and a truncating instance share all
// inputs and are checked against an integer-sqrt reference model.
module tb_psdsqrt_hs;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        out_ready;
  logic [31:0] xin;

  logic        in_ready, busy, out_valid, exact, sat;
  logic [19:0] sqrt;
  logic        in_ready0, busy0, out_valid0, exact0, sat0;
  logic [19:0] sqrt0;

  int vectors     = 0;
  int miscompares = 0;

  logic [19:0] got_s, got_s0;
  logic        got_e, got_t, got_e0, got_t0;
  int          got_lat;

  always #5 clock = ~clock;

  psdsqrt_hs #(.NBITSIN(32), .NFRAC(4), .ROUND(1)) u_dut (
    .clock(clock), .reset(reset), .start(start), .xin(xin), .in_ready(in_ready),
    .abort(abort), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .sqrt(sqrt), .exact(exact), .sat(sat)
  );

  psdsqrt_hs #(.NBITSIN(32), .NFRAC(4), .ROUND(0)) u_trunc (
    .clock(clock), .reset(reset), .start(start), .xin(xin), .in_ready(in_ready0),
    .abort(abort), .busy(busy0), .out_valid(out_valid0), .out_ready(out_ready),
    .sqrt(sqrt0), .exact(exact0), .sat(sat0)
  );

  // Reference: largest q with q*q <= x*4^(nfrac+rnd), then optional round-half-up.
  function automatic void model(input logic [31:0] x, input int nfrac, input int rnd,
                                input int nout, output logic [19:0] s,
                                output logic e, output logic st);
    longint unsigned n, lo, hi, mid, q, full;
    n  = {32'd0, x} << (2 * (nfrac + rnd));
    lo = 0;
    hi = 64'd1 << (nout + rnd);
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= n) lo = mid;
      else hi = mid;
    end
    q    = lo;
    e    = (q * q == n);
    st   = 1'b0;
    full = q;
    if (rnd != 0) begin
      full = (q + 1) >> 1;
      if (full >= (64'd1 << nout)) begin
        full = (64'd1 << nout) - 1;
        st   = 1'b1;
      end
    end
    s = full[19:0];
  endfunction

  task automatic run_op(input logic [31:0] x, input bit hold);
    int cyc;
    bit seen0;
    start = 1'b1;
    xin   = x;
    @(negedge clock);
    start = 1'b0;
    xin   = $urandom;
    cyc   = 0;
    seen0 = 1'b0;
    while (!out_valid && cyc < 100) begin
      if (out_valid0 && !seen0) begin
        got_s0 = sqrt0; got_e0 = exact0; got_t0 = sat0; seen0 = 1'b1;
      end
      @(negedge clock);
      cyc++;
    end
    if (out_valid0 && !seen0) begin
      got_s0 = sqrt0; got_e0 = exact0; got_t0 = sat0; seen0 = 1'b1;
    end
    got_s = sqrt; got_e = exact; got_t = sat; got_lat = cyc;
    vectors++;
    if (cyc !== 22 || !seen0) begin
      miscompares++;
      $display("[TB] FAIL latency x=%0d: got %0d edges (trunc seen=%0d), expected 22", x, cyc, seen0);
    end
    if (!hold) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; xin = '0;
    repeat (2) @(negedge clock);
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || sqrt !== 20'd0 ||
        exact !== 1'b0 || sat !== 1'b0 || in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: in_ready=%b busy=%b out_valid=%b sqrt=%0d exact=%b sat=%b, expected 1 0 0 0 0 0",
               in_ready, busy, out_valid, sqrt, exact, sat);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_directed();
    run_op(32'd144, 1'b0);
    vectors++;
    if (got_s !== 20'd192 || got_e !== 1'b1 || got_t !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sqrt_144: got %0d e=%b s=%b, expected 192 e=1 s=0", got_s, got_e, got_t);
    end
    run_op(32'd123456, 1'b0);
    vectors++;
    if (got_s !== 20'd5622 || got_e !== 1'b0 || got_t !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sqrt_123456: got %0d e=%b s=%b, expected 5622 e=0 s=0", got_s, got_e, got_t);
    end
    run_op(32'd12, 1'b0);
    vectors++;
    if (got_s !== 20'd55 || got_e !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sqrt_12: got %0d e=%b, expected 55 e=0", got_s, got_e);
    end
    run_op(32'hFFFF_FFFF, 1'b0);
    vectors++;
    if (got_s !== 20'hFFFFF || got_t !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sat_round: got %h sat=%b, expected fffff sat=1", got_s, got_t);
    end
    vectors++;
    if (got_s0 !== 20'hFFFFF || got_t0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sat_trunc: got %h sat=%b, expected fffff sat=0", got_s0, got_t0);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    out_ready = 1'b0;
    run_op(32'd123456, 1'b1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (sqrt !== 20'd5622 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      start = (i == 3);
      xin   = 32'd144;
      abort = (i == 5);
      @(negedge clock);
    end
    start = 1'b0;
    abort = 1'b0;
    vectors++;
    if (bad != 0 || sqrt !== 20'd5622 || out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL backpressure_hold: %0d bad cycles, sqrt=%0d out_valid=%b, expected 0 bad, 5622, 1",
               bad, sqrt, out_valid);
    end
    out_ready = 1'b1;
    @(negedge clock);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || busy0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL backpressure_release: in_ready=%b out_valid=%b busy=%b, expected 1 0 0",
               in_ready, out_valid, busy);
    end
    run_op(32'd12, 1'b0);
    vectors++;
    if (got_s !== 20'd55) begin
      miscompares++;
      $display("[TB] FAIL after_backpressure: got %0d, expected 55", got_s);
    end
  endtask

  task automatic test_abort();
    int rose;
    run_op(32'd144, 1'b0);
    start = 1'b1;
    xin   = 32'd543210;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || sqrt !== 20'd192 ||
        exact !== 1'b1 || sat !== 1'b0 || in_ready0 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_state: busy=%b in_ready=%b out_valid=%b sqrt=%0d exact=%b, expected 0 1 0 192 1",
               busy, in_ready, out_valid, sqrt, exact);
    end
    rose = 0;
    repeat (30) begin
      if (out_valid !== 1'b0 || out_valid0 !== 1'b0) rose++;
      @(negedge clock);
    end
    vectors++;
    if (rose != 0) begin
      miscompares++;
      $display("[TB] FAIL abort_no_valid: out_valid high in %0d cycles, expected 0", rose);
    end
    run_op(32'd144, 1'b0);
    vectors++;
    if (got_s !== 20'd192 || got_e !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL after_abort: got %0d e=%b, expected 192 e=1", got_s, got_e);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    xin   = 32'd987654;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || sqrt !== 20'd0 ||
        exact !== 1'b0 || sat !== 1'b0 || busy0 !== 1'b0 || sqrt0 !== 20'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: busy=%b in_ready=%b out_valid=%b sqrt=%0d exact=%b, expected 0 1 0 0 0",
               busy, in_ready, out_valid, sqrt, exact);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [31:0] x;
    logic [19:0] es, es0;
    logic        ee, et, ee0, et0;
    int          k;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       x = $urandom_range(0, 1000);
        1: begin k = $urandom_range(0, 65535); x = k * k; end
        default: x = $urandom;
      endcase
      model(x, 4, 1, 20, es, ee, et);
      model(x, 4, 0, 20, es0, ee0, et0);
      run_op(x, 1'b0);
      vectors++;
      if (got_s !== es || got_e !== ee || got_t !== et) begin
        miscompares++;
        $display("[TB] FAIL random_round x=%0d: got %0d e=%b s=%b, expected %0d e=%b s=%b",
                 x, got_s, got_e, got_t, es, ee, et);
      end
      vectors++;
      if (got_s0 !== es0 || got_e0 !== ee0 || got_t0 !== et0) begin
        miscompares++;
        $display("[TB] FAIL random_trunc x=%0d: got %0d e=%b s=%b, expected %0d e=%b s=%b",
                 x, got_s0, got_e0, got_t0, es0, ee0, et0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
